missile_scheduler: RTL and testbench

//  Owns the three invader missile slots (m1..m3) drawn by the VGA path. Once per frame it

---
 rtl/missile_scheduler_if.sv | 39 +++
 rtl/missile_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_missile_scheduler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/missile_scheduler_if.sv
// missile_scheduler_if
//   Groups the game-side signals of the invader missile scheduler.
//   master: frame/enable/clear strobes, invader alive mask and formation origin,
//           player position and collision level in; slot positions, active mask
//           and player_hit pulse out.
//   slave : the scheduler side of the same signals.
interface missile_scheduler_if #(
    parameter int unsigned INVADERS_H = 11,
    parameter int unsigned INVADERS_V = 5
);
    logic                               frame;
    logic                               enable;
    logic                               clear;
    logic [INVADERS_H*INVADERS_V-1:0]   invaders;
    logic [9:0]                         invaders_x;
    logic [9:0]                         invaders_y;
    logic [9:0]                         player_y;
    logic                               player_collision;
    logic [9:0]                         m1_x;
    logic [9:0]                         m1_y;
    logic [9:0]                         m2_x;
    logic [9:0]                         m2_y;
    logic [9:0]                         m3_x;
    logic [9:0]                         m3_y;
    logic [2:0]                         m_active;
    logic                               player_hit;

    modport master (
        output frame, enable, clear, invaders, invaders_x, invaders_y, player_y,
               player_collision,
        input  m1_x, m1_y, m2_x, m2_y, m3_x, m3_y, m_active, player_hit
    );

    modport slave (
        input  frame, enable, clear, invaders, invaders_x, invaders_y, player_y,
               player_collision,
        output m1_x, m1_y, m2_x, m2_y, m3_x, m3_y, m_active, player_hit
    );
endinterface

// File: rtl/missile_scheduler.sv
// missile_scheduler
//   Owns the three invader missile slots. Once per frame it advances active
//   missiles, retires those leaving the screen or hitting the player, and on
//   fire-timer expiry picks a firing column round-robin and launches from the
//   lowest live invader of that column into the lowest free slot. Inactive
//   slots are parked at (1023,1023).
// Ports
//   clk    : system clock
//   arst_n : asynchronous reset, active low
//   bus    : missile_scheduler_if.slave (frame/enable/clear, invader mask and
//            origin, player position/collision in; slot positions, m_active,
//            player_hit out)
module missile_scheduler #(
    parameter int unsigned INVADERS_H    = 11,
    parameter int unsigned INVADERS_V    = 5,
    parameter int unsigned OFFSET_H      = 32,
    parameter int unsigned OFFSET_V      = 24,
    parameter int unsigned SPR_W         = 24,
    parameter int unsigned SPR_H         = 16,
    parameter int unsigned PROJ_H        = 8,
    parameter int unsigned MISSILE_SPEED = 2,
    parameter int unsigned SCREEN_BOTTOM = 480,
    parameter int unsigned FIRE_PERIOD   = 48
) (
    input logic                clk,
    input logic                arst_n,
    missile_scheduler_if.slave bus
);
    localparam int unsigned ColW   = (INVADERS_H > 1) ? $clog2(INVADERS_H) : 1;
    localparam int unsigned RowW   = (INVADERS_V > 1) ? $clog2(INVADERS_V) : 1;
    localparam int unsigned TimerW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;

    localparam logic [TimerW-1:0] TimerReload = TimerW'(FIRE_PERIOD - 1);
    localparam logic [ColW-1:0]   LastCol     = ColW'(INVADERS_H - 1);
    localparam logic [10:0]       Bottom      = 11'(SCREEN_BOTTOM);
    localparam logic [10:0]       Speed       = 11'(MISSILE_SPEED);
    localparam logic [11:0]       ProjH       = 12'(PROJ_H);
    localparam logic [9:0]        Parked      = 10'd1023;

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StFireChk,
        StScan,
        StLaunch
    } state_e;

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic              hit_flag_q, hit_flag_d;
    logic              player_hit_q, player_hit_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [ColW-1:0]   rr_q, rr_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [ColW-1:0]   scanned_q, scanned_d;
    logic [2:0]        active_q, active_d;
    logic [9:0]        x_q [3];
    logic [9:0]        x_d [3];
    logic [9:0]        y_q [3];
    logic [9:0]        y_d [3];

    // Lowest live invader in the current column: highest row index wins.
    logic            row_found;
    logic [RowW-1:0] row_sel;

    always_comb begin
        row_found = 1'b0;
        row_sel   = '0;
        for (int r = 0; r < int'(INVADERS_V); r++) begin
            if (bus.invaders[r*int'(INVADERS_H) + int'(col_q)]) begin
                row_found = 1'b1;
                row_sel   = RowW'(r);
            end
        end
    end

    logic [1:0] free_idx;

    always_comb begin
        free_idx = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (!active_q[i]) free_idx = 2'(i);
        end
    end

    logic [10:0] new_y;
    logic        kill;
    logic        any_hit;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        hit_flag_d   = hit_flag_q;
        player_hit_d = 1'b0;
        timer_d      = timer_q;
        rr_d         = rr_q;
        col_d        = col_q;
        scanned_d    = scanned_q;
        active_d     = active_q;
        x_d          = x_q;
        y_d          = y_q;
        new_y        = '0;
        kill         = 1'b0;
        any_hit      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pending_q && bus.enable) begin
                    pending_d = 1'b0;
                    state_d   = StMove;
                end
            end
            StMove: begin
                for (int i = 0; i < 3; i++) begin
                    if (active_q[i]) begin
                        // 11-bit sum so a missile near 1023 cannot wrap back on screen.
                        new_y = {1'b0, y_q[i]} + Speed;
                        kill  = (new_y >= Bottom);
                        if (hit_flag_q && (({1'b0, new_y} + ProjH) >= {2'b0, bus.player_y})) begin
                            kill    = 1'b1;
                            any_hit = 1'b1;
                        end
                        if (kill) begin
                            active_d[i] = 1'b0;
                            x_d[i]      = Parked;
                            y_d[i]      = Parked;
                        end else begin
                            y_d[i] = new_y[9:0];
                        end
                    end
                end
                if (hit_flag_q) begin
                    hit_flag_d   = 1'b0;
                    player_hit_d = any_hit;
                end
                state_d = StFireChk;
            end
            StFireChk: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                    state_d = StIdle;
                end else if (&active_q) begin
                    // Timer held at zero so the next frame retries.
                    state_d = StIdle;
                end else begin
                    col_d     = rr_q;
                    scanned_d = '0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (row_found) begin
                    state_d = StLaunch;
                end else if (scanned_q == LastCol) begin
                    state_d = StIdle;
                end else begin
                    col_d     = (col_q == LastCol) ? '0 : col_q + 1'b1;
                    scanned_d = scanned_q + 1'b1;
                end
            end
            StLaunch: begin
                // Row is re-derived from the mask seen this cycle; if the column
                // died since the scan, nothing is launched and the timer stays 0.
                if (row_found && !(&active_q)) begin
                    active_d[free_idx] = 1'b1;
                    x_d[free_idx] = bus.invaders_x + 10'(int'(col_q) * int'(OFFSET_H))
                                  + 10'(SPR_W / 2);
                    y_d[free_idx] = bus.invaders_y + 10'(int'(row_sel) * int'(OFFSET_V))
                                  + 10'(SPR_H);
                    rr_d    = (col_q == LastCol) ? '0 : col_q + 1'b1;
                    timer_d = TimerReload;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Frame set after servicing so a frame coinciding with service is kept.
        if (bus.frame && bus.enable) pending_d = 1'b1;
        if (bus.player_collision) hit_flag_d = 1'b1;

        if (bus.clear) begin
            active_d = '0;
            for (int i = 0; i < 3; i++) begin
                x_d[i] = Parked;
                y_d[i] = Parked;
            end
            timer_d = TimerReload;
            rr_d    = '0;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= StIdle;
            pending_q    <= 1'b0;
            hit_flag_q   <= 1'b0;
            player_hit_q <= 1'b0;
            timer_q      <= TimerReload;
            rr_q         <= '0;
            col_q        <= '0;
            scanned_q    <= '0;
            active_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                x_q[i] <= Parked;
                y_q[i] <= Parked;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            hit_flag_q   <= hit_flag_d;
            player_hit_q <= player_hit_d;
            timer_q      <= timer_d;
            rr_q         <= rr_d;
            col_q        <= col_d;
            scanned_q    <= scanned_d;
            active_q     <= active_d;
            for (int i = 0; i < 3; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign bus.m1_x       = x_q[0];
    assign bus.m1_y       = y_q[0];
    assign bus.m2_x       = x_q[1];
    assign bus.m2_y       = y_q[1];
    assign bus.m3_x       = x_q[2];
    assign bus.m3_y       = y_q[2];
    assign bus.m_active   = active_q;
    assign bus.player_hit = player_hit_q;
endmodule

// File: tb/tb_missile_scheduler.sv
// tb_missile_scheduler
//   Directed bench for missile_scheduler. dut uses FIRE_PERIOD=1 (launch
//   attempt every frame); dut2 shares its stimulus with FIRE_PERIOD=3 to
//   exercise the fire timer countdown and reload.
module tb_missile_scheduler;
    logic clk;
    logic arst_n;
    int   tests;
    int   fails;
    int   hit_cnt;

    missile_scheduler_if bus ();
    missile_scheduler_if bus2 ();

    missile_scheduler #(.FIRE_PERIOD(1)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    missile_scheduler #(.FIRE_PERIOD(3)) dut2 (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus2.slave)
    );

    assign bus2.frame            = bus.frame;
    assign bus2.enable           = bus.enable;
    assign bus2.clear            = bus.clear;
    assign bus2.invaders         = bus.invaders;
    assign bus2.invaders_x       = bus.invaders_x;
    assign bus2.invaders_y       = bus.invaders_y;
    assign bus2.player_y         = bus.player_y;
    assign bus2.player_collision = bus.player_collision;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial hit_cnt = 0;
    always @(negedge clk) if (bus.player_hit === 1'b1) hit_cnt <= hit_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_frame();
        @(negedge clk);
        bus.frame = 1'b1;
        @(negedge clk);
        bus.frame = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [54:0] all_alive;
    logic [54:0] col1_dead;

    initial begin
        tests = 0;
        fails = 0;
        all_alive = '1;
        col1_dead = '1;
        for (int r = 0; r < 5; r++) col1_dead[r*11 + 1] = 1'b0;

        arst_n               = 1'b0;
        bus.frame            = 1'b0;
        bus.enable           = 1'b1;
        bus.clear            = 1'b0;
        bus.invaders         = all_alive;
        bus.invaders_x       = 10'd100;
        bus.invaders_y       = 10'd50;
        bus.player_y         = 10'd400;
        bus.player_collision = 1'b0;
        repeat (3) @(negedge clk);

        check("reset m_active", 32'(bus.m_active), 0);
        check("reset m1_x", 32'(bus.m1_x), 1023);
        check("reset m3_y", 32'(bus.m3_y), 1023);
        check("reset player_hit", 32'(bus.player_hit), 0);
        arst_n = 1'b1;
        @(negedge clk);

        // First frame: col 0, row 4.
        do_frame();
        check("f1 m_active", 32'(bus.m_active), 1);
        check("f1 m1_x", 32'(bus.m1_x), 112);
        check("f1 m1_y", 32'(bus.m1_y), 162);
        check("f1 dut2 idle", 32'(bus2.m_active), 0);

        // Column 1 dead: rr_ptr=1 skips to col 2.
        bus.invaders = col1_dead;
        do_frame();
        check("f2 m_active", 32'(bus.m_active), 3);
        check("f2 m1_y moved", 32'(bus.m1_y), 164);
        check("f2 m2_x", 32'(bus.m2_x), 176);
        check("f2 m2_y", 32'(bus.m2_y), 162);
        check("f2 dut2 idle", 32'(bus2.m_active), 0);

        do_frame();
        check("f3 m_active", 32'(bus.m_active), 7);
        check("f3 m3_x", 32'(bus.m3_x), 208);
        check("f3 m3_y", 32'(bus.m3_y), 162);
        check("f3 dut2 m_active", 32'(bus2.m_active), 1);
        check("f3 dut2 m1_x", 32'(bus2.m1_x), 112);
        check("f3 dut2 m1_y", 32'(bus2.m1_y), 162);

        // All slots busy: move only.
        do_frame();
        check("f4 m_active", 32'(bus.m_active), 7);
        check("f4 m1_y", 32'(bus.m1_y), 168);
        check("f4 m3_y", 32'(bus.m3_y), 164);
        check("f4 m3_x", 32'(bus.m3_x), 208);
        check("f4 dut2 no relaunch", 32'(bus2.m_active), 1);
        check("f4 dut2 m1_y", 32'(bus2.m1_y), 164);

        pulse_clear();
        check("clear m_active", 32'(bus.m_active), 0);
        check("clear m2_x", 32'(bus.m2_x), 1023);
        check("clear m3_y", 32'(bus.m3_y), 1023);

        // Bottom retirement.
        bus.invaders   = all_alive;
        bus.invaders_y = 10'd364;
        do_frame();
        check("bot launch m1_y", 32'(bus.m1_y), 476);
        check("bot launch m1_x", 32'(bus.m1_x), 112);
        bus.invaders   = '0;
        bus.invaders_y = 10'd0;
        do_frame();
        check("bot 478 m1_y", 32'(bus.m1_y), 478);
        check("bot 478 m_active", 32'(bus.m_active), 1);
        do_frame();
        check("bot retired m_active", 32'(bus.m_active), 0);
        check("bot retired m1_x", 32'(bus.m1_x), 1023);
        check("bot retired m1_y", 32'(bus.m1_y), 1023);

        // Player hit. rr_ptr is 1 (empty scans left it unchanged).
        bus.invaders   = all_alive;
        bus.invaders_y = 10'd280;
        do_frame();
        check("hit launch m1_x", 32'(bus.m1_x), 144);
        check("hit launch m1_y", 32'(bus.m1_y), 392);
        bus.invaders_y = 10'd0;
        do_frame();
        check("near player no flag m1_y", 32'(bus.m1_y), 394);
        check("hit m2_x", 32'(bus.m2_x), 176);
        check("hit m_active before", 32'(bus.m_active), 3);
        check("no hit yet", 32'(hit_cnt), 0);
        bus.player_collision = 1'b1;
        @(negedge clk);
        bus.player_collision = 1'b0;
        bus.invaders = '0;
        repeat (3) @(negedge clk);
        check("hit deferred to MOVE", 32'(bus.m_active), 3);
        do_frame();
        check("hit m_active after", 32'(bus.m_active), 2);
        check("hit m1_y parked", 32'(bus.m1_y), 1023);
        check("hit m2_y kept", 32'(bus.m2_y), 114);
        check("hit pulse count", 32'(hit_cnt), 1);
        do_frame();
        check("hit flag serviced once", 32'(hit_cnt), 1);
        check("hit m2_y later", 32'(bus.m2_y), 116);

        // Empty formation scan, then async reset mid-scan.
        @(negedge clk);
        bus.frame = 1'b1;
        @(negedge clk);
        bus.frame = 1'b0;
        repeat (5) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("rst mid-scan m_active", 32'(bus.m_active), 0);
        check("rst mid-scan m2_x", 32'(bus.m2_x), 1023);
        check("rst mid-scan m2_y", 32'(bus.m2_y), 1023);
        check("rst mid-scan player_hit", 32'(bus.player_hit), 0);
        @(negedge clk);
        arst_n = 1'b1;
        bus.invaders   = all_alive;
        bus.invaders_y = 10'd50;
        do_frame();
        check("post-rst rr col0 m1_x", 32'(bus.m1_x), 112);
        check("post-rst m1_y", 32'(bus.m1_y), 162);

        // enable=0 freezes.
        bus.enable = 1'b0;
        do_frame();
        check("disabled m1_y frozen", 32'(bus.m1_y), 162);
        check("disabled m_active frozen", 32'(bus.m_active), 1);
        bus.enable = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
